// File: rtl/qc_pkg.sv
// Shared fixed-point complex number types for the gate sequencer and the multiplier datapath.
// Values are 8-bit sign-magnitude with 6 fraction bits.
package qc_pkg;

  localparam int         FIX_FRAC = 6;
  localparam logic [7:0] FIX_ONE  = 8'h40;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
  } complexNum;

endpackage

// File: rtl/cs_state_reg.sv
// Holds the 2**N-amplitude state vector.
// Loads the initial vector (priority) or a multiplier result.
module cs_state_reg
  import qc_pkg::*;
#(
  parameter int N = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_init,
  input  logic                  load_result,
  input  complexNum [2**N-1:0]  init_state,
  input  complexNum [2**N-1:0]  result,
  output complexNum [2**N-1:0]  q
);

  // NOTE: the vector is small and must read as all-zero straight after reset, so it gets the async clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load_init) begin
      q <= init_state;
    end else if (load_result) begin
      q <= result;
    end
  end

endmodule

// File: rtl/circuit_sequencer.sv
// Steps a program of gate matrices through the shared gate x state multiplier.
// Each result is committed back into the held state vector.
module circuit_sequencer
  import qc_pkg::*;
#(
  parameter int N          = 1,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CNT_W-1:0]               num_gates,
  input  complexNum [2**N-1:0]           init_state,
  input  logic                           abort,
  input  logic                           gate_valid,
  output logic                           gate_ready,
  input  complexNum [2**N-1:0][2**N-1:0] gate_in,
  output complexNum [2**N-1:0]           mult_state,
  output complexNum [2**N-1:0][2**N-1:0] mult_gate,
  input  complexNum [2**N-1:0]           mult_result,
  output complexNum [2**N-1:0]           out_state,
  output logic [CNT_W-1:0]               gates_done,
  output logic                           busy,
  output logic                           done
);

  localparam int DIM = 2**N;
  localparam int SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_GATE, SETTLE, COMMIT, DONE} fsm_t;

  fsm_t                           fsm;
  complexNum [DIM-1:0][DIM-1:0]   gate_reg;
  complexNum [DIM-1:0]            state_q;
  logic [CNT_W-1:0]               count;
  logic [CNT_W-1:0]               count_next;
  logic [CNT_W-1:0]               num_reg;
  logic [SW-1:0]                  settle_cnt;
  logic                           load_init;
  logic                           load_result;

  // An abort in the commit cycle must leave the last committed vector untouched.
  assign load_init   = (fsm == IDLE) && start && !abort;
  assign load_result = (fsm == COMMIT) && !abort;
  assign count_next  = count + CNT_W'(1);

  cs_state_reg #(.N(N)) u_state_reg (
    .clk         (clk),
    .reset       (reset),
    .load_init   (load_init),
    .load_result (load_result),
    .init_state  (init_state),
    .result      (mult_result),
    .q           (state_q)
  );

  assign mult_state = state_q;
  assign out_state  = state_q;
  assign mult_gate  = gate_reg;
  assign gates_done = count;

  // NOTE: non-blocking assignments so every register here sees the pre-edge value of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm        <= IDLE;
      gate_reg   <= '0;
      count      <= '0;
      num_reg    <= '0;
      settle_cnt <= '0;
      gate_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && fsm != IDLE) begin
        fsm        <= IDLE;
        busy       <= 1'b0;
        gate_ready <= 1'b0;
      end else begin
        unique case (fsm)
          IDLE: begin
            if (start && !abort) begin
              num_reg <= num_gates;
              count   <= '0;
              busy    <= 1'b1;
              if (num_gates == '0) begin
                fsm  <= DONE;
                done <= 1'b1;
              end else begin
                fsm        <= WAIT_GATE;
                gate_ready <= 1'b1;
              end
            end
          end
          WAIT_GATE: begin
            if (gate_valid) begin
              gate_reg   <= gate_in;
              settle_cnt <= SW'(SETTLE_CYC - 1);
              gate_ready <= 1'b0;
              fsm        <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == '0) begin
              fsm <= COMMIT;
            end else begin
              settle_cnt <= settle_cnt - SW'(1);
            end
          end
          COMMIT: begin
            count <= count_next;
            if (count_next == num_reg) begin
              fsm  <= DONE;
              done <= 1'b1;
            end else begin
              fsm        <= WAIT_GATE;
              gate_ready <= 1'b1;
            end
          end
          DONE: begin
            fsm  <= IDLE;
            busy <= 1'b0;
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule
